uart_tx_scheduler: RTL and testbench

//   Shares one UART transmit line among NUM_REQ byte requesters with round-robin arbitration.

---
 rtl/uart_tx_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin arbiter and 8N1/8N2 serializer that lets NUM_REQ byte
//   requesters share one UART transmit line. Bit timing comes from the
//   txclk_en strobe generated by baud_rate_gen. Each strobe starts one bit.
//
// Ports
//   clk_50m    : system clock
//   rst_n      : asynchronous active-low reset
//   txclk_en   : one-cycle bit-time strobe
//   req_valid  : per-requester byte valid
//   req_data   : byte of requester i at [8*i+7:8*i]
//   req_ready  : one-hot accept (combinational, IDLE only)
//   grant_id   : requester owning the current / most recent frame
//   busy       : high while a frame (including gap) is in progress
//   frame_done : one-cycle pulse when the frame returns to IDLE
//   tx         : serial line, idle high
module uart_tx_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int STOP_BITS = 1,
   parameter int GAP_TICKS = 0,
   localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk_50m,
   input  logic                 rst_n,
   input  logic                 txclk_en,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [GW-1:0]        grant_id,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 tx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP,
      S_GAP
   } state_t;

   localparam logic [3:0] GAP_LAST = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

   state_t        state_q, state_d;
   logic [GW-1:0] ptr_q, ptr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [7:0]    data_q, data_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          win_found;
   logic [GW-1:0] win_idx;
   int unsigned   idx;

   // Round-robin search starting at ptr_q, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr_q) + k) % NUM_REQ;
         if (!win_found && req_valid[idx[GW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = idx[GW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state_q == S_IDLE && win_found) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Each strobe starts the next bit. The frame returns to IDLE on the strobe
   // that starts its last high bit, so a frame accepted in that IDLE cycle
   // puts its start bit exactly where the previous frame's last bit ends.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      data_d    = data_q;
      bit_idx_d = bit_idx_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (win_found) begin
               data_d  = req_data[8*win_idx +: 8];
               grant_d = win_idx;
               if (int'(win_idx) == NUM_REQ - 1) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = win_idx + GW'(1);
               end
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (txclk_en) begin
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (txclk_en) begin
               tx_d      = data_q[0];
               bit_idx_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (txclk_en) begin
               if (bit_idx_q != 3'd7) begin
                  tx_d      = data_q[bit_idx_q + 3'd1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end else begin
                  tx_d = 1'b1;
                  if (STOP_BITS > 1) begin
                     state_d = S_STOP;
                  end else if (GAP_TICKS > 0) begin
                     cnt_d   = '0;
                     state_d = S_GAP;
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         S_STOP: begin
            if (txclk_en) begin
               tx_d = 1'b1;
               if (GAP_TICKS > 0) begin
                  cnt_d   = '0;
                  state_d = S_GAP;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (txclk_en) begin
               tx_d = 1'b1;
               if (cnt_q == GAP_LAST) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         data_q    <= '0;
         bit_idx_q <= '0;
         cnt_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         bit_idx_q <= bit_idx_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a queue-based line model checked every cycle
// plus directed scenarios with literal expectations. A second instance runs
// with STOP_BITS=2, GAP_TICKS=1.
module tb_uart_tx_scheduler;

   localparam int N = 4;

   logic           clk_50m   = 1'b0;
   logic           rst_n     = 1'b0;
   logic           txclk_en  = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data  = '0;
   logic [N-1:0]   req_ready;
   logic [1:0]     grant_id;
   logic           busy, frame_done, tx;

   logic [N-1:0]   req_valid4 = '0;
   logic [8*N-1:0] req_data4  = '0;
   logic [N-1:0]   req_ready4;
   logic [1:0]     grant_id4;
   logic           busy4, frame_done4, tx4;

   uart_tx_scheduler #(.NUM_REQ(N), .STOP_BITS(1), .GAP_TICKS(0)) dut (
      .clk_50m(clk_50m), .rst_n(rst_n), .txclk_en(txclk_en),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .tx(tx)
   );

   uart_tx_scheduler #(.NUM_REQ(N), .STOP_BITS(2), .GAP_TICKS(1)) dut4 (
      .clk_50m(clk_50m), .rst_n(rst_n), .txclk_en(txclk_en),
      .req_valid(req_valid4), .req_data(req_data4), .req_ready(req_ready4),
      .grant_id(grant_id4), .busy(busy4), .frame_done(frame_done4), .tx(tx4)
   );

   always #5 clk_50m = ~clk_50m;

   // Bit-time strobe: one cycle in every eight, changed 1 time unit after the edge.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk_50m);
         #1;
         ph = (ph + 1) % 8;
         txclk_en = (ph == 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int checks   = 0;
   int failures = 0;
   int ord[8];

   // Line model: a frame is a list of line levels, one popped per strobe.
   bit m_active = 1'b0;
   bit m_busy   = 1'b0;
   bit m_done   = 1'b0;
   bit m_tx     = 1'b1;
   int m_grant  = 0;
   int m_ptr    = 0;
   bit mq[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int winner(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_loop();
      forever begin
         @(posedge clk_50m or negedge rst_n);
         if (!rst_n) begin
            m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_tx = 1'b1;
            m_grant = 0; m_ptr = 0; mq.delete();
         end else begin
            m_done = 1'b0;
            if (!m_active) begin
               int w;
               w = winner(req_valid, m_ptr);
               if (w >= 0) begin
                  logic [7:0] d;
                  d = req_data[8*w +: 8];
                  mq.delete();
                  mq.push_back(1'b0);
                  for (int b = 0; b < 8; b++) mq.push_back(d[b]);
                  mq.push_back(1'b1);
                  m_grant = w; m_ptr = (w + 1) % N;
                  m_active = 1'b1; m_busy = 1'b1;
               end
            end else if (txclk_en) begin
               m_tx = mq.pop_front();
               if (mq.size() == 0) begin
                  m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic compare_loop();
      forever begin
         logic [N-1:0] er;
         int w;
         @(negedge clk_50m);
         er = '0;
         w = winner(req_valid, m_ptr);
         if (rst_n && !m_active && w >= 0) er[w] = 1'b1;
         chk("model_tx", tx, m_tx);
         chk("model_busy", busy, m_busy);
         chk("model_frame_done", frame_done, m_done);
         chk("model_grant_id", grant_id, m_grant);
         chk("model_req_ready", req_ready, er);
      end
   endtask

   // Returns at strobe edge + 1.
   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk_50m);
         if (txclk_en) seen = 1'b1;
      end
      #1;
      if (!seen) chk("tick_wait_timeout", 0, 1);
   endtask

   // Returns at posedge + 2 once busy has dropped.
   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int c = 0; c < 400 && !idle; c++) begin
         @(negedge clk_50m);
         if (!busy) idle = 1'b1;
      end
      if (!idle) chk("idle_wait_timeout", 0, 1);
      @(posedge clk_50m);
      #2;
   endtask

   // Hold requests from mask; record the first n grants in ord[].
   task automatic serve(input logic [N-1:0] mask, input bit sticky, input int n);
      logic [N-1:0] m;
      int got;
      m = mask;
      got = 0;
      for (int i = 0; i < 8; i++) ord[i] = -1;
      req_valid = m;
      for (int c = 0; c < 100 * (n + 1) && got < n; c++) begin
         @(negedge clk_50m);
         if ((req_ready & req_valid) != '0) begin
            int i;
            i = 0;
            for (int k = 0; k < N; k++) if (req_ready[k]) i = k;
            ord[got] = i;
            got++;
            @(posedge clk_50m);
            #2;
            if (!sticky) m[i] = 1'b0;
            req_valid = (got < n) ? m : '0;
         end
      end
      req_valid = '0;
      if (got < n) chk("serve_timeout", got, n);
   endtask

   initial begin
      int exp1[10];
      int seen_done;
      int busy_cnt;
      exp1 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

      fork
         model_loop();
         compare_loop();
      join_none

      // Reset state
      #12;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_frame_done", frame_done, 0);
      #11 rst_n = 1'b1;
      @(posedge clk_50m);
      #2;

      // All four requesters held: round-robin order, back-to-back frames
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      serve(4'b1111, 1'b1, 5);
      chk("t2_order0", ord[0], 0);
      chk("t2_order1", ord[1], 1);
      chk("t2_order2", ord[2], 2);
      chk("t2_order3", ord[3], 3);
      chk("t2_order4", ord[4], 0);
      wait_idle();

      // Req0 sends 0xA5
      wait_tick();
      #1;
      req_data[7:0] = 8'hA5;
      req_valid = 4'b0001;
      @(negedge clk_50m);
      chk("t1_ready_pulse", req_ready, 4'b0001);
      @(posedge clk_50m);
      #2;
      req_valid = '0;
      @(negedge clk_50m);
      chk("t1_ready_after", req_ready, 4'b0000);
      for (int k = 0; k < 10; k++) begin
         wait_tick();
         chk($sformatf("t1_tx_tick%0d", k + 1), tx, exp1[k]);
      end
      chk("t1_frame_done", frame_done, 1);
      chk("t1_busy_end", busy, 0);
      @(posedge clk_50m);
      #1;
      chk("t1_frame_done_width", frame_done, 0);
      wait_idle();

      // Pointer after req0; then req2 alone; then req1+req3
      serve(4'b0100, 1'b0, 1);
      chk("t3_grant_req2", ord[0], 2);
      chk("t3_grant_id", grant_id, 2);
      wait_idle();
      serve(4'b1010, 1'b0, 2);
      chk("t3_first_req3", ord[0], 3);
      chk("t3_then_req1", ord[1], 1);
      wait_idle();
      chk("t3_grant_hold", grant_id, 1);

      // Strobe coincident with acceptance is ignored
      begin
         bit al;
         al = 1'b0;
         for (int c = 0; c < 20 && !al; c++) begin
            @(posedge clk_50m);
            #2;
            if (txclk_en) al = 1'b1;
         end
         if (!al) chk("t6_align_timeout", 0, 1);
      end
      req_data[15:8] = 8'h5A;
      req_valid = 4'b0010;
      @(posedge clk_50m);
      #1;
      chk("t6_tx_hold", tx, 1);
      chk("t6_busy", busy, 1);
      chk("t6_grant", grant_id, 1);
      #1;
      req_valid = 4'b0100;
      repeat (3) @(posedge clk_50m);
      #2;
      req_valid = '0;
      wait_tick();
      chk("t6_start_bit", tx, 0);
      wait_idle();
      repeat (3) @(posedge clk_50m);
      #2;
      chk("t6_no_grant_busy", busy, 0);
      chk("t6_no_grant_id", grant_id, 1);

      // Reset mid-frame during data bit 4 (byte 0x00 so the line is low there)
      req_data[7:0] = 8'h00;
      serve(4'b0001, 1'b0, 1);
      repeat (6) wait_tick();
      chk("t5_bit4_low", tx, 0);
      @(posedge clk_50m);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_tx_abort", tx, 1);
      chk("t5_busy_abort", busy, 0);
      chk("t5_ready_abort", req_ready, 0);
      @(posedge clk_50m);
      #3;
      rst_n = 1'b1;
      seen_done = 0;
      repeat (100) begin
         @(negedge clk_50m);
         if (frame_done) seen_done++;
      end
      chk("t5_no_frame_done", seen_done, 0);
      @(posedge clk_50m);
      #2;
      serve(4'b1001, 1'b0, 1);
      chk("t5_lowest_index", ord[0], 0);
      wait_idle();

      // STOP_BITS=2, GAP_TICKS=1, byte 0x00
      wait_tick();
      #1;
      req_data4[7:0] = 8'h00;
      req_valid4 = 4'b0001;
      @(posedge clk_50m);
      #1;
      chk("t4_busy_accept", busy4, 1);
      #1;
      req_valid4 = '0;
      seen_done = 0;
      busy_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         wait_tick();
         chk($sformatf("t4_tx_tick%0d", k + 1), tx4, (k < 9) ? 0 : 1);
         if (k < 11) begin
            if (frame_done4) seen_done++;
            if (busy4) busy_cnt++;
         end
      end
      chk("t4_no_early_done", seen_done, 0);
      chk("t4_busy_throughout", busy_cnt, 11);
      chk("t4_frame_done", frame_done4, 1);
      chk("t4_busy_end", busy4, 0);
      @(posedge clk_50m);
      #1;
      chk("t4_frame_done_width", frame_done4, 0);
      repeat (4) @(posedge clk_50m);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
